secded_dmem_scrub: RTL and testbench
====================================

# secded_dmem_scrub

Parametrised SECDED (extended Hamming) protected data memory for the pipeline MEM stage, replacing the fixed-width ECC dmem. It encodes on write, corrects single-bit and flags double-bit errors on read, and clears its array at reset. A background scrubber walks the array during idle cycles and writes back corrected words. A bench-only fault-injection port flips stored codeword bits directly, so tests need no hierarchical pokes.

## Interface
- DATA_W, 32: data word width, 8..64
- DEPTH, 256: words, power of two
- SCRUB_EN, 1: 0 disables the scrubber
- SCRUB_INTERVAL, 1024: idle cycles between scrub reads, ≥2
- CNT_W, 16: error counter width
- Derived: ADDR_W = clog2(DEPTH); P = smallest p with 2^p ≥ DATA_W+p+1; CODE_W = DATA_W+P+1 (39 for DATA_W=32)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  access request
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  read data valid, one-cycle pulse
- rsp_rdata  out  DATA_W  corrected read data
- rsp_sbe  out  1  single-bit error corrected
- rsp_dbe  out  1  double-bit error, data uncorrected
- inj_valid  in  1  fault-injection strobe
- inj_addr  in  ADDR_W  injection address
- inj_mask  in  CODE_W  XOR mask applied to the stored codeword
- sbe_count  out  CNT_W  saturating SBE count
- dbe_count  out  CNT_W  saturating DBE count
- last_err_addr  out  ADDR_W  address of most recent SBE/DBE
- scrub_busy  out  1  scrubber owns array this cycle

## Operation
- Codeword layout: bit 0 is overall parity. Positions 1..CODE_W-1 are Hamming positions. Parity bits sit at powers of two. Data bits fill the remaining positions in ascending order, so data bit 0 is at position 3.
- Decode uses syndrome s and overall parity mismatch m:
  - s=0, m=0: clean.
  - m=1: SBE; flip position s (s=0 means bit 0 only); data corrected.
  - s≠0, m=0: DBE; rsp_rdata = raw stored data bits.
- Single-port array, one access per cycle. Priority: inj > scrub writeback > port request > scrub read.
- FSM states:
  - INIT: entered from reset. Writes encode(0) to addresses 0..DEPTH-1, one per cycle. req_ready=0. Goes to IDLE after address DEPTH-1.
  - IDLE: serves requests. The idle timer increments on cycles with no accepted request and no injection. When the timer reaches SCRUB_INTERVAL-1 and req_valid=0, the block issues a scrub read of scrub_ptr, clears the timer and goes to SCRUB_CHK.
  - SCRUB_CHK: decodes the scrub word.
    - SBE: go to SCRUB_WB.
    - DBE: no writeback, back to IDLE.
    - Clean: back to IDLE.
    - In all three cases scrub_ptr increments, wrapping DEPTH-1 to 0.
  - SCRUB_WB: writes the corrected codeword. req_ready=0. Returns to IDLE.
- A port request arriving in the cycle the timer expires wins, and the timer holds at its terminal value.
- Counters and last_err_addr update on every SBE/DBE, from port reads and scrub alike. Counters saturate at all-ones.
- inj_valid forces req_ready=0 that cycle. It is ignored during INIT.
- Reset mid-operation: any pending rsp is dropped, counters, scrub_ptr and timer clear, and the FSM re-enters INIT.

## Timing
- Reset values:
  - req_ready=0, rsp_*=0, scrub_busy=0, counts=0, last_err_addr=0.
  - First cycle after rst deasserts: INIT, address 0.
  - req_ready first rises DEPTH cycles after rst deasserts.
- Read latency: request accepted at edge N gives rsp_valid plus data/flags registered at edge N+1, high for exactly one cycle.
- Writes produce no response.
- Write then read of the same address on consecutive cycles returns the new data.
- Back-to-back reads are sustained at one per cycle.
- scrub_busy is high during the scrub-read cycle and the SCRUB_WB cycle.
- Counters and last_err_addr update in the same cycle as the flagging rsp, or one cycle after the scrub read for scrub errors.
- Injection takes effect from the next cycle.

## Structure
- Package ecc_pkg holds:
  - the CODE_W/P computation function;
  - the FSM state encoding (INIT, IDLE, SCRUB_CHK, SCRUB_WB);
  - encode and decode functions parametrised on DATA_W.
- Sub-module secded_codec is a combinational encoder plus decoder. It is instantiated twice: once on the port path and once on the scrub path, or shared through a mux.

## Test plan
- Init: release rst, then read addresses 0 and 255 → req_ready rises after 256 cycles; both reads return 0, sbe=0, dbe=0.
- Clean path: write 0x0000000A to address 1, then read address 1 → rsp_rdata=0x0000000A with no flags, one cycle after acceptance.
- Single error: inject mask bit 6 at address 1, then read → rsp_rdata=0x0000000A (raw 0x0000000E), rsp_sbe=1, sbe_count=1, last_err_addr=1.
- Double error: write 0x0000000A to address 1, inject mask bits 5 and 6, then read → rsp_dbe=1, rsp_rdata=0x0000000C, dbe_count=1.
- Scrub: with SCRUB_INTERVAL=4, inject bit 6 at address 1 and idle 20 cycles → one SCRUB_WB seen with req_ready=0 that cycle; a subsequent read returns 0x0000000A with rsp_sbe=0.
- Saturation and arbitration, with CNT_W=2:
  - Five SBE reads → sbe_count=3.
  - A request held valid across a SCRUB_WB cycle is accepted exactly one cycle later, with no loss or duplicate response.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: check-bit sizing, FSM state encoding, and the
// extended-Hamming encode/decode functions for data widths up to 64 bits.
package ecc_pkg;

    localparam int MAX_DW = 64;
    localparam int MAX_CW = 72;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SCRUB_CHK,
        S_SCRUB_WB
    } state_t;

    typedef struct packed {
        logic [MAX_DW-1:0] data;
        logic              sbe;
        logic              dbe;
    } dec_t;

    // Smallest p with 2^p >= dw + p + 1.
    function automatic int calc_p(input int dw);
        int r;
        r = 7;
        for (int p = 7; p >= 1; p--) begin
            if ((1 << p) >= dw + p + 1) r = p;
        end
        return r;
    endfunction

    function automatic logic [MAX_CW-1:0] encode(input logic [MAX_DW-1:0] d, input int dw);
        logic [MAX_CW-1:0] c;
        logic              par;
        int                cw;
        int                j;
        cw = dw + calc_p(dw) + 1;
        c  = '0;
        j  = 0;
        for (int pos = 1; pos < MAX_CW; pos++) begin
            if (pos < cw && (pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 7; k++) begin
            par = 1'b0;
            for (int pos = 1; pos < MAX_CW; pos++) begin
                if (pos < cw && (pos & (1 << k)) != 0) par ^= c[pos];
            end
            if ((1 << k) < cw) c[1 << k] = par;
        end
        c[0] = ^c;
        return c;
    endfunction

    // Odd overall parity means one flipped bit at position s (s=0: the parity bit
    // itself); even parity with a non-zero syndrome is an uncorrectable pair.
    function automatic dec_t decode(input logic [MAX_CW-1:0] c, input int dw);
        dec_t              r;
        logic [MAX_CW-1:0] f;
        logic              m;
        int                cw;
        int                s;
        int                j;
        cw = dw + calc_p(dw) + 1;
        s  = 0;
        for (int pos = 1; pos < MAX_CW; pos++) begin
            if (pos < cw && c[pos]) s ^= pos;
        end
        m     = ^c;
        f     = c;
        r.sbe = 1'b0;
        r.dbe = 1'b0;
        if (m) begin
            r.sbe = 1'b1;
            if (s < cw) f[s] = ~f[s];
        end else if (s != 0) begin
            r.dbe = 1'b1;
        end
        r.data = '0;
        j      = 0;
        for (int pos = 1; pos < MAX_CW; pos++) begin
            if (pos < cw && (pos & (pos - 1)) != 0) begin
                r.data[j] = f[pos];
                j++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/secded_codec.sv
// Combinational SECDED encoder and decoder pair sized for one data width.
module secded_codec
    import ecc_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int CODE_W = DATA_W + calc_p(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] enc_data_i,
    output logic [CODE_W-1:0] enc_code_o,
    input  logic [CODE_W-1:0] dec_code_i,
    output logic [DATA_W-1:0] dec_data_o,
    output logic              dec_sbe_o,
    output logic              dec_dbe_o
);
    logic [MAX_CW-1:0] enc_full;
    dec_t              dec;
    logic              unused_hi;

    assign enc_full   = encode(MAX_DW'(enc_data_i), DATA_W);
    assign dec        = decode(MAX_CW'(dec_code_i), DATA_W);
    assign enc_code_o = enc_full[CODE_W-1:0];
    assign dec_data_o = dec.data[DATA_W-1:0];
    assign dec_sbe_o  = dec.sbe;
    assign dec_dbe_o  = dec.dbe;
    // Bits above the configured width are always zero.
    assign unused_hi  = ^{enc_full, dec.data};
endmodule

// File: rtl/secded_dmem_scrub.sv
// SECDED-protected single-port data memory with reset-time clearing,
// idle-time background scrubbing and a direct codeword fault-injection port.
module secded_dmem_scrub
    import ecc_pkg::*;
#(
    parameter  int DATA_W         = 32,
    parameter  int DEPTH          = 256,
    parameter  int SCRUB_EN       = 1,
    parameter  int SCRUB_INTERVAL = 1024,
    parameter  int CNT_W          = 16,
    localparam int ADDR_W         = $clog2(DEPTH),
    localparam int CODE_W         = DATA_W + calc_p(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_sbe,
    output logic              rsp_dbe,
    input  logic              inj_valid,
    input  logic [ADDR_W-1:0] inj_addr,
    input  logic [CODE_W-1:0] inj_mask,
    output logic [CNT_W-1:0]  sbe_count,
    output logic [CNT_W-1:0]  dbe_count,
    output logic [ADDR_W-1:0] last_err_addr,
    output logic              scrub_busy
);
    localparam int TMR_W = $clog2(SCRUB_INTERVAL);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(SCRUB_INTERVAL - 1);
    localparam logic [CODE_W-1:0] ZERO_CODE = CODE_W'(encode('0, DATA_W));

    logic [CODE_W-1:0] mem_q [DEPTH];
    state_t            state_q;
    logic [ADDR_W-1:0] scrub_ptr_q, wb_addr_q;
    logic [TMR_W-1:0]  timer_q;
    logic [CODE_W-1:0] wb_code_q;
    logic              chk_sbe_q;
    logic              rsp_valid_q, rsp_sbe_q, rsp_dbe_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [CNT_W-1:0]  sbe_cnt_q, dbe_cnt_q;
    logic [ADDR_W-1:0] last_err_q;

    logic [CODE_W-1:0] p_enc, s_enc;
    logic [DATA_W-1:0] p_data, s_data;
    logic              p_sbe, p_dbe, s_sbe, s_dbe;
    logic              accept, port_rd, scrub_rd, inj_ok, wb_hazard;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [CODE_W-1:0] mem_wdata;

    secded_codec #(.DATA_W(DATA_W)) u_port_codec (
        .enc_data_i(req_wdata),        .enc_code_o(p_enc),
        .dec_code_i(mem_q[req_addr]),  .dec_data_o(p_data),
        .dec_sbe_o (p_sbe),            .dec_dbe_o (p_dbe)
    );

    // Scrub path re-encodes its own corrected data to form the writeback word.
    secded_codec #(.DATA_W(DATA_W)) u_scrub_codec (
        .enc_data_i(s_data),              .enc_code_o(s_enc),
        .dec_code_i(mem_q[scrub_ptr_q]),  .dec_data_o(s_data),
        .dec_sbe_o (s_sbe),               .dec_dbe_o (s_dbe)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign req_ready  = !rst && !inj_valid && (state_q == S_IDLE || state_q == S_SCRUB_CHK);
    assign accept     = req_valid && req_ready;
    assign port_rd    = accept && !req_we;
    assign inj_ok     = inj_valid && !rst && state_q != S_INIT;
    assign scrub_rd   = (SCRUB_EN != 0) && !rst && state_q == S_IDLE && timer_q == TMR_MAX
                        && !req_valid && !inj_valid;
    // A port write landing on the word under check makes the pending writeback stale.
    assign wb_hazard  = accept && req_we && req_addr == wb_addr_q;
    assign scrub_busy = scrub_rd || (!rst && state_q == S_SCRUB_WB);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_addr;
        mem_wdata = p_enc;
        if (inj_ok) begin
            mem_we    = 1'b1;
            mem_waddr = inj_addr;
            mem_wdata = mem_q[inj_addr] ^ inj_mask;
        end else if (state_q == S_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = scrub_ptr_q;
            mem_wdata = ZERO_CODE;
        end else if (state_q == S_SCRUB_WB) begin
            mem_we    = 1'b1;
            mem_waddr = wb_addr_q;
            mem_wdata = wb_code_q;
        end else if (accept && req_we) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            scrub_ptr_q <= '0;
            timer_q     <= '0;
            wb_addr_q   <= '0;
            wb_code_q   <= '0;
            chk_sbe_q   <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    scrub_ptr_q <= scrub_ptr_q + ADDR_W'(1);
                    if (scrub_ptr_q == ADDR_W'(DEPTH - 1)) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (scrub_rd) begin
                        timer_q   <= '0;
                        wb_addr_q <= scrub_ptr_q;
                        wb_code_q <= s_enc;
                        chk_sbe_q <= s_sbe;
                        state_q   <= S_SCRUB_CHK;
                    end else if (!accept && !inj_valid && timer_q != TMR_MAX) begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_SCRUB_CHK: begin
                    scrub_ptr_q <= scrub_ptr_q + ADDR_W'(1);
                    state_q     <= (chk_sbe_q && !wb_hazard) ? S_SCRUB_WB : S_IDLE;
                end
                S_SCRUB_WB: begin
                    if (!inj_valid) state_q <= S_IDLE;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_sbe_q   <= 1'b0;
            rsp_dbe_q   <= 1'b0;
            sbe_cnt_q   <= '0;
            dbe_cnt_q   <= '0;
            last_err_q  <= '0;
        end else begin
            rsp_valid_q <= port_rd;
            rsp_sbe_q   <= port_rd && p_sbe;
            rsp_dbe_q   <= port_rd && p_dbe;
            if (port_rd) rsp_rdata_q <= p_data;
            if (port_rd && (p_sbe || p_dbe)) begin
                if (p_sbe) sbe_cnt_q <= sat_inc(sbe_cnt_q);
                if (p_dbe) dbe_cnt_q <= sat_inc(dbe_cnt_q);
                last_err_q <= req_addr;
            end else if (scrub_rd && (s_sbe || s_dbe)) begin
                if (s_sbe) sbe_cnt_q <= sat_inc(sbe_cnt_q);
                if (s_dbe) dbe_cnt_q <= sat_inc(dbe_cnt_q);
                last_err_q <= scrub_ptr_q;
            end
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_sbe       = rsp_sbe_q;
    assign rsp_dbe       = rsp_dbe_q;
    assign sbe_count     = sbe_cnt_q;
    assign dbe_count     = dbe_cnt_q;
    assign last_err_addr = last_err_q;
endmodule

// File: tb/tb_secded_dmem_scrub.sv
// Directed bench: instance 0 (scrubber off, 16-bit counters) runs the vector
// table; instance 1 (SCRUB_INTERVAL=4, CNT_W=2) covers scrub, arbitration, saturation.
module tb_secded_dmem_scrub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [7:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_sbe   [2];
    logic        rsp_dbe   [2];
    logic        inj_valid [2];
    logic [7:0]  inj_addr  [2];
    logic [38:0] inj_mask  [2];
    logic [7:0]  last_err  [2];
    logic        scrub_busy[2];
    logic [15:0] sbe_cnt0, dbe_cnt0;
    logic [1:0]  sbe_cnt1, dbe_cnt1;

    int n_cmp  = 0;
    int n_fail = 0;
    int wb_seen = 0;
    int busy0_seen = 0;

    secded_dmem_scrub #(.DATA_W(32), .DEPTH(256), .SCRUB_EN(0), .SCRUB_INTERVAL(1024), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_sbe(rsp_sbe[0]), .rsp_dbe(rsp_dbe[0]),
        .inj_valid(inj_valid[0]), .inj_addr(inj_addr[0]), .inj_mask(inj_mask[0]),
        .sbe_count(sbe_cnt0), .dbe_count(dbe_cnt0), .last_err_addr(last_err[0]), .scrub_busy(scrub_busy[0])
    );

    secded_dmem_scrub #(.DATA_W(32), .DEPTH(256), .SCRUB_EN(1), .SCRUB_INTERVAL(4), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_sbe(rsp_sbe[1]), .rsp_dbe(rsp_dbe[1]),
        .inj_valid(inj_valid[1]), .inj_addr(inj_addr[1]), .inj_mask(inj_mask[1]),
        .sbe_count(sbe_cnt1), .dbe_count(dbe_cnt1), .last_err_addr(last_err[1]), .scrub_busy(scrub_busy[1])
    );

    // Writeback cycles are the only ones with scrub_busy high and req_ready low.
    always @(negedge clk) begin
        if (!rst && scrub_busy[1] && !req_ready[1]) wb_seen++;
        if (!rst && scrub_busy[0]) busy0_seen++;
    end

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [38:0] mask;
        logic [31:0] exp_data;
        bit          exp_sbe;
        bit          exp_dbe;
        int          exp_sc;
        int          exp_dc;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present a request and return #1 after the edge that accepts it.
    task automatic issue(input int k, input bit we, input logic [7:0] a, input logic [31:0] wd,
                         output int waited);
        logic rdy;
        waited = 0;
        req_we[k] = we; req_addr[k] = a; req_wdata[k] = wd; req_valid[k] = 1'b1;
        forever begin
            @(negedge clk);
            rdy = req_ready[k];
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 64'(waited), 64'd0);
                break;
            end
        end
    endtask

    task automatic inject(input int k, input logic [7:0] a, input logic [38:0] m);
        req_valid[k] = 1'b0;
        inj_valid[k] = 1'b1; inj_addr[k] = a; inj_mask[k] = m;
        @(posedge clk);
        #1;
        inj_valid[k] = 1'b0;
    endtask

    initial begin
        int   w;
        int   exp_last;
        bit   found;
        logic [38:0] one;
        one = 39'd1;

        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_we[k] = 0; req_addr[k] = '0; req_wdata[k] = '0;
            inj_valid[k] = 0; inj_addr[k] = '0; inj_mask[k] = '0;
        end

        //            we addr    wdata         mask                    exp_data      sbe dbe sc dc
        tbl[0]  = '{0, 8'd0,   32'h0,        39'h0,                  32'h0,        0, 0, 0, 0};
        tbl[1]  = '{0, 8'd255, 32'h0,        39'h0,                  32'h0,        0, 0, 0, 0};
        tbl[2]  = '{1, 8'd1,   32'h0000000A, 39'h0,                  32'h0,        0, 0, 0, 0};
        tbl[3]  = '{0, 8'd1,   32'h0,        39'h0,                  32'h0000000A, 0, 0, 0, 0};
        tbl[4]  = '{0, 8'd1,   32'h0,        one << 6,               32'h0000000A, 1, 0, 1, 0};
        tbl[5]  = '{1, 8'd1,   32'h0000000A, 39'h0,                  32'h0,        0, 0, 1, 0};
        tbl[6]  = '{0, 8'd1,   32'h0,        (one << 5) | (one << 6), 32'h0000000C, 0, 1, 1, 1};
        tbl[7]  = '{1, 8'd2,   32'h12345678, 39'h0,                  32'h0,        0, 0, 1, 1};
        tbl[8]  = '{1, 8'd3,   32'hFFFFFFFF, 39'h0,                  32'h0,        0, 0, 1, 1};
        tbl[9]  = '{0, 8'd2,   32'h0,        39'h0,                  32'h12345678, 0, 0, 1, 1};
        tbl[10] = '{0, 8'd3,   32'h0,        one,                    32'hFFFFFFFF, 1, 0, 2, 1};
        tbl[11] = '{0, 8'd2,   32'h0,        one << 38,              32'h12345678, 1, 0, 3, 1};
        tbl[12] = '{0, 8'd2,   32'h0,        one << 1,               32'h92345678, 0, 1, 3, 2};
        tbl[13] = '{1, 8'd4,   32'hCAFEF00D, 39'h0,                  32'h0,        0, 0, 3, 2};
        tbl[14] = '{0, 8'd4,   32'h0,        39'h0,                  32'hCAFEF00D, 0, 0, 3, 2};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", 64'(req_ready[k]), 0);
            check("rst_rsp_valid", 64'(rsp_valid[k]), 0);
            check("rst_last_err", 64'(last_err[k]), 0);
            check("rst_busy", 64'(scrub_busy[k]), 0);
        end
        check("rst_sbe0", 64'(sbe_cnt0), 0);
        check("rst_dbe1", 64'(dbe_cnt1), 0);

        repeat (255) @(posedge clk);
        #1;
        check("init_ready_early0", 64'(req_ready[0]), 0);
        check("init_ready_early1", 64'(req_ready[1]), 0);
        @(posedge clk);
        #1;
        check("init_ready_rise0", 64'(req_ready[0]), 1);
        check("init_ready_rise1", 64'(req_ready[1]), 1);

        exp_last = 0;
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].mask != 0) inject(0, tbl[i].addr, tbl[i].mask);
            issue(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, w);
            check($sformatf("v%0d_nowait", i), 64'(w), 0);
            check($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid[0]), 64'(!tbl[i].we));
            if (!tbl[i].we) begin
                if (tbl[i].exp_sbe || tbl[i].exp_dbe) exp_last = tbl[i].addr;
                check($sformatf("v%0d_rdata", i), 64'(rsp_rdata[0]), 64'(tbl[i].exp_data));
                check($sformatf("v%0d_sbe", i), 64'(rsp_sbe[0]), 64'(tbl[i].exp_sbe));
                check($sformatf("v%0d_dbe", i), 64'(rsp_dbe[0]), 64'(tbl[i].exp_dbe));
                check($sformatf("v%0d_sbe_cnt", i), 64'(sbe_cnt0), 64'(tbl[i].exp_sc));
                check($sformatf("v%0d_dbe_cnt", i), 64'(dbe_cnt0), 64'(tbl[i].exp_dc));
                check($sformatf("v%0d_last_err", i), 64'(last_err[0]), 64'(exp_last));
            end
        end
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        check("rsp_pulse_end", 64'(rsp_valid[0]), 0);
        check("no_scrub_when_disabled", 64'(busy0_seen), 0);

        // Scrub writeback and a request held across it.
        issue(1, 1'b1, 8'd1, 32'h0000000A, w);
        inject(1, 8'd1, one << 6);
        found = 0;
        for (int c = 0; c < 4000 && !found; c++) begin
            @(negedge clk);
            if (scrub_busy[1] && !req_ready[1]) found = 1;
        end
        check("scrub_wb_found", 64'(found), 1);
        req_we[1] = 1'b0; req_addr[1] = 8'd1; req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("arb_ready_after_wb", 64'(req_ready[1]), 1);
        check("arb_no_early_rsp", 64'(rsp_valid[1]), 0);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check("arb_rsp_valid", 64'(rsp_valid[1]), 1);
        check("scrub_fixed_data", 64'(rsp_rdata[1]), 64'h0000000A);
        check("scrub_fixed_sbe", 64'(rsp_sbe[1]), 0);
        check("scrub_sbe_cnt", 64'(sbe_cnt1), 1);
        check("scrub_last_err", 64'(last_err[1]), 1);
        @(posedge clk);
        #1;
        check("arb_no_dup_rsp", 64'(rsp_valid[1]), 0);
        repeat (20) @(posedge clk);
        #1;
        check("scrub_wb_count", 64'(wb_seen), 1);

        // Saturating SBE counter (CNT_W=2).
        inject(1, 8'd2, one << 3);
        for (int i = 0; i < 5; i++) begin
            issue(1, 1'b0, 8'd2, 32'h0, w);
            check($sformatf("sat%0d_rdata", i), 64'(rsp_rdata[1]), 0);
            check($sformatf("sat%0d_sbe", i), 64'(rsp_sbe[1]), 1);
            check($sformatf("sat%0d_cnt", i), 64'(sbe_cnt1), 64'((i + 2 > 3) ? 3 : i + 2));
        end
        issue(1, 1'b1, 8'd2, 32'h0, w);
        req_valid[1] = 1'b0;
        check("sat_dbe_cnt", 64'(dbe_cnt1), 0);
        check("sat_last_err", 64'(last_err[1]), 2);

        // Reset during operation drops the pending response and re-clears the array.
        issue(0, 1'b0, 8'd4, 32'h0, w);
        req_valid[0] = 1'b0;
        check("pre_rst_rsp", 64'(rsp_valid[0]), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_rsp_drop", 64'(rsp_valid[0]), 0);
        check("mid_rst_sbe0", 64'(sbe_cnt0), 0);
        check("mid_rst_dbe0", 64'(dbe_cnt0), 0);
        check("mid_rst_sbe1", 64'(sbe_cnt1), 0);
        check("mid_rst_last", 64'(last_err[0]), 0);
        check("mid_rst_ready", 64'(req_ready[0]), 0);
        repeat (256) @(posedge clk);
        #1;
        check("reinit_ready", 64'(req_ready[0]), 1);
        issue(0, 1'b0, 8'd4, 32'h0, w);
        req_valid[0] = 1'b0;
        check("reinit_cleared", 64'(rsp_rdata[0]), 0);
        check("reinit_sbe", 64'(rsp_sbe[0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
